// File: rtl/stopwatch_bcd_pkg.sv
// Shared types and digit limits for the MM:SS:CC BCD stopwatch.
package stopwatch_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int         DIGIT_W    = 4;
  localparam int         NUM_DIGITS = 6;
  localparam logic [3:0] CC_MAX     = 4'd9;
  localparam logic [3:0] TENS_MAX   = 4'd5;

  // Saturating compare also folds any out-of-range code back to zero.
  function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] q,
                                                 input logic [DIGIT_W-1:0] max);
    if (q >= max) begin
      return 4'd0;
    end else begin
      return q + 4'd1;
    end
  endfunction

  // Digit order is cc_lo, cc_hi, ss_lo, ss_hi, mm_lo, mm_hi; only the tens of seconds/minutes stop at 5.
  function automatic logic [DIGIT_W-1:0] digit_max(input int idx);
    return ((idx == 3) || (idx == 5)) ? TENS_MAX : CC_MAX;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit of the stopwatch; digits are chained carry -> inc.
module stopwatch_bcd_digit
  import stopwatch_bcd_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = CC_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [DIGIT_W-1:0] q_nxt,
  output logic               carry
);

  logic [DIGIT_W-1:0] q_r;

  // Next digit value and ripple carry, resolved in the same cycle.
  always_comb begin
    q_nxt = q_r;
    if (clr) begin
      q_nxt = 4'd0;
    end else if (inc) begin
      q_nxt = bcd_inc(q_r, MAX);
    end else begin
      q_nxt = q_r;
    end
    carry = inc && (q_r == MAX);
  end

  // Digit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= 4'd0;
    end else begin
      q_r <= q_nxt;
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// Six-digit BCD stopwatch (MM:SS:CC) with start/stop, clear and lap freeze.
// Every output is a register loaded from next-state values, so outputs follow the causing edge.
module stopwatch_bcd
  import stopwatch_bcd_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] hex4,
  output logic [3:0] hex5,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  localparam int              PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  state_t            state_r, state_nxt_s;
  logic [PS_W-1:0]   ps_r, ps_nxt_s;
  logic              run_s, tick_s, clear_act_s, lap_act_s, running_nxt_s;
  logic [5:0]        inc_s, carry_s;
  logic [23:0]       live_nxt_s, snap_r, snap_nxt_s, hex_r;
  logic              lap_r, lap_nxt_s, ov_r, ov_nxt_s, running_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; outside RUN a clear beats a simultaneous start_stop.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (clear) state_nxt_s = ST_IDLE;
        else if (start_stop) state_nxt_s = ST_RUN;
        else state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (start_stop) state_nxt_s = ST_PAUSE;
        else state_nxt_s = ST_RUN;
      end
      ST_PAUSE: begin
        if (clear) state_nxt_s = ST_IDLE;
        else if (start_stop) state_nxt_s = ST_RUN;
        else state_nxt_s = ST_PAUSE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM-derived control strobes.
  always_comb begin
    run_s         = (state_r == ST_RUN);
    clear_act_s   = clear && ((state_r == ST_IDLE) || (state_r == ST_PAUSE));
    lap_act_s     = lap && run_s;
    tick_s        = run_s && (ps_r == PS_LAST);
    running_nxt_s = (state_nxt_s == ST_RUN);
  end

  // Prescaler holds its phase while paused so a resume keeps the sub-tick position.
  always_comb begin
    ps_nxt_s = ps_r;
    if (clear_act_s) begin
      ps_nxt_s = {PS_W{1'b0}};
    end else if (run_s) begin
      ps_nxt_s = tick_s ? {PS_W{1'b0}} : ps_r + PS_W'(1);
    end else begin
      ps_nxt_s = ps_r;
    end
  end

  assign inc_s = {carry_s[4:0], tick_s};

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    stopwatch_bcd_digit #(
      .MAX (digit_max(i))
    ) u_dig (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_s[i]),
      .clr   (clear_act_s),
      .q_nxt (live_nxt_s[DIGIT_W*i +: DIGIT_W]),
      .carry (carry_s[i])
    );
  end

  // Lap snapshot, overflow flag and display selection.
  always_comb begin
    snap_nxt_s = snap_r;
    lap_nxt_s  = lap_r;
    ov_nxt_s   = ov_r;
    if (clear_act_s) begin
      lap_nxt_s = 1'b0;
      ov_nxt_s  = 1'b0;
    end else begin
      if (carry_s[5]) ov_nxt_s = 1'b1;
      else ov_nxt_s = ov_r;
      if (lap_act_s && lap_r) begin
        lap_nxt_s = 1'b0;
      end else if (lap_act_s) begin
        lap_nxt_s  = 1'b1;
        snap_nxt_s = live_nxt_s;
      end else begin
        lap_nxt_s = lap_r;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_r      <= {PS_W{1'b0}};
      snap_r    <= 24'd0;
      lap_r     <= 1'b0;
      ov_r      <= 1'b0;
      hex_r     <= 24'd0;
      running_r <= 1'b0;
    end else begin
      ps_r      <= ps_nxt_s;
      snap_r    <= snap_nxt_s;
      lap_r     <= lap_nxt_s;
      ov_r      <= ov_nxt_s;
      hex_r     <= lap_nxt_s ? snap_nxt_s : live_nxt_s;
      running_r <= running_nxt_s;
    end
  end

  assign hex0       = hex_r[3:0];
  assign hex1       = hex_r[7:4];
  assign hex2       = hex_r[11:8];
  assign hex3       = hex_r[15:12];
  assign hex4       = hex_r[19:16];
  assign hex5       = hex_r[23:20];
  assign running    = running_r;
  assign lap_active = lap_r;
  assign overflow   = ov_r;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench for stopwatch_bcd: directed vector table, corner sequences and
// random pulses checked against a centisecond-count reference model.
module tb_stopwatch_bcd;

  localparam int TICK_DIV = 4;
  localparam int WRAP_CS  = 360000;
  localparam logic [26:0] M_ALL = 27'h7ffffff;
  localparam logic [26:0] M_HEX = 27'h7fffff8;
  localparam logic [26:0] M_RUN = 27'h0000004;
  localparam logic [26:0] M_LA  = 27'h0000002;
  localparam logic [26:0] M_OV  = 27'h0000001;

  logic       clk = 1'b0;
  logic       rst = 1'b1, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [3:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       running, lap_active, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: elapsed centiseconds and control flags
  int m_mode = 0;  // 0 idle, 1 run, 2 pause
  int m_phase = 0;
  int m_t = 0;
  int m_snap = 0;
  bit m_lap = 1'b0;
  bit m_ov = 1'b0;

  always #5 clk = ~clk;

  stopwatch_bcd #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .running(running), .lap_active(lap_active), .overflow(overflow)
  );

  function automatic logic [23:0] to_hex(input int v);
    int mm, ss, cc;
    mm = v / 6000;
    ss = (v / 100) % 60;
    cc = v % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic logic [26:0] dut_vec();
    return {hex5, hex4, hex3, hex2, hex1, hex0, running, lap_active, overflow};
  endfunction

  function automatic logic [26:0] model_vec();
    return {to_hex(m_lap ? m_snap : m_t), (m_mode == 1), m_lap, m_ov};
  endfunction

  task automatic model_edge(input bit rs, input bit ss, input bit cl, input bit lp);
    bit run, tick;
    run  = (m_mode == 1);
    tick = 1'b0;
    if (rs) begin
      m_mode = 0; m_phase = 0; m_t = 0; m_snap = 0; m_lap = 1'b0; m_ov = 1'b0;
    end else begin
      if (run) begin
        if (m_phase == TICK_DIV - 1) begin tick = 1'b1; m_phase = 0; end
        else m_phase++;
      end
      if (tick) begin
        m_t++;
        if (m_t == WRAP_CS) begin m_t = 0; m_ov = 1'b1; end
      end
      if (run && lp) begin
        if (m_lap) m_lap = 1'b0;
        else begin m_lap = 1'b1; m_snap = m_t; end
      end
      if (run) begin
        if (ss) m_mode = 2;
      end else if (cl) begin
        m_t = 0; m_phase = 0; m_lap = 1'b0; m_ov = 1'b0; m_mode = 0;
      end else if (ss) begin
        m_mode = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [26:0] exp, input logic [26:0] mask);
    logic [26:0] got;
    got = dut_vec();
    n_checks++;
    if ((got & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (mask %h) at %0t", name, got & mask, exp & mask, mask, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not reached within cycle budget", name);
  endtask

  // one clock: drive, model the edge, compare everything one step later
  task automatic step(input bit rs, input bit ss, input bit cl, input bit lp);
    rst = rs; start_stop = ss; clear = cl; lap = lp;
    @(posedge clk);
    model_edge(rs, ss, cl, lp);
    #1;
    check("model", model_vec(), M_ALL);
    rst = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  typedef struct {
    bit          rs, ss, cl, lp;
    int          hold;
    logic [23:0] hex;
    bit          run, la, ov;
  } vec_t;

  vec_t tbl [8];
  bit   found;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,   24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,   24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,   24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 19,  24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 548, 24'h000137, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 40,  24'h000137, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 2,   24'h000137, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 0,   24'h000138, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rs, tbl[i].ss, tbl[i].cl, tbl[i].lp);
      repeat (tbl[i].hold) step(1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("vec%0d", i), {tbl[i].hex, tbl[i].run, tbl[i].la, tbl[i].ov}, M_ALL);
    end

    // lap freeze / release, lap ignored while paused
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("clear_zero", 27'h0, M_ALL);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (48) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_freeze", {24'h000012, 1'b1, 1'b1, 1'b0}, M_HEX | M_RUN | M_LA);
    repeat (70) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_release", {24'h000030, 1'b1, 1'b0, 1'b0}, M_HEX | M_LA);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_in_pause", {24'h000030, 1'b0, 1'b1, 1'b0}, M_HEX | M_RUN | M_LA);

    // simultaneous start_stop + clear, clear ignored while running
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("ss_clr_pause", 27'h0, M_ALL);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_in_run", {24'h000002, 1'b1, 1'b0, 1'b0}, M_HEX | M_RUN);
    repeat (9) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("ss_clr_run", {24'h000005, 1'b0, 1'b0, 1'b0}, M_HEX | M_RUN);

    // preload 59:59:98 while paused, then roll over
    force dut.g_dig[0].u_dig.q_r = 4'd8;
    force dut.g_dig[1].u_dig.q_r = 4'd9;
    force dut.g_dig[2].u_dig.q_r = 4'd9;
    force dut.g_dig[3].u_dig.q_r = 4'd5;
    force dut.g_dig[4].u_dig.q_r = 4'd9;
    force dut.g_dig[5].u_dig.q_r = 4'd5;
    m_t = 359998;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    release dut.g_dig[0].u_dig.q_r;
    release dut.g_dig[1].u_dig.q_r;
    release dut.g_dig[2].u_dig.q_r;
    release dut.g_dig[3].u_dig.q_r;
    release dut.g_dig[4].u_dig.q_r;
    release dut.g_dig[5].u_dig.q_r;
    check("preload", {24'h595998, 1'b0, 1'b0, 1'b0}, M_HEX | M_OV);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (m_t == 359999) found = 1'b1;
    end
    if (found) check("max_time", {24'h595999, 1'b1, 1'b0, 1'b0}, M_HEX | M_RUN | M_OV);
    else bound_fail("max_time");
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (m_t == 0) found = 1'b1;
    end
    if (found) check("wrap", {24'h000000, 1'b1, 1'b0, 1'b1}, M_HEX | M_RUN | M_OV);
    else bound_fail("wrap");
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("ovf_sticky", {24'h000000, 1'b1, 1'b0, 1'b1}, M_RUN | M_OV);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_ovf", 27'h0, M_ALL);

    // reset in the middle of a run
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_run", 27'h0, M_ALL);

    // random control pulses against the model
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(499) == 0), ($urandom_range(39) == 0),
           ($urandom_range(29) == 0), ($urandom_range(24) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
